acct_regfile_multi: RTL and testbench
=====================================

Name: acct_regfile_multi

Overview:
Parametrised multi-master access-control register file; successor to the single-slave access-control register block. Holds per-master, per-peripheral permission fields in software-written shadow registers. Applies them atomically to the live acc_ctrl_o vector through a commit FSM that waits for fabric quiescence, with a timeout. Sits on the peripheral register bus next to the register-lock block and drives the interconnect permission checkers.

Parameters:
NB_MASTER, 2, number of bus masters (initiator channels); NB_MASTER*NW <= 256
NB_PERIPHERALS, 9, number of peripherals per master
ACC_BITS, 4, permission bits per (master, peripheral)
ADDR_WIDTH, 12, register bus byte address width
TIMEOUT, 16, max cycles in WAIT_Q before the commit aborts (>=1)

Derived:
- NW = ceil(NB_PERIPHERALS*ACC_BITS/32), words per master.
- Word index = addr_i[ADDR_WIDTH-1:2].

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  bus request
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_WIDTH  byte address
wdata_i  in  32  write data
gnt_o  out  1  grant (= req_i, always accepts)
rvalid_o  out  1  response valid, 1 cycle after an accepted request (reads and writes)
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  error, valid with rvalid_o
reglk_ctrl_i  in  NB_MASTER  external write-lock per master
rd_hide_i  in  NB_MASTER  external read-hide per master
commit_ok_i  in  1  fabric quiescent, commit may apply
acc_ctrl_o  out  NB_MASTER*NB_PERIPHERALS*ACC_BITS  active permissions; master m at slice [m*NB_PERIPHERALS*ACC_BITS +: NB_PERIPHERALS*ACC_BITS]
commit_done_o  out  1  one-cycle pulse when the active registers are updated

Behaviour:
Address map by word index:
- 0..NB_MASTER*NW-1: shadow words, RW; master m, word w at m*NW+w.
- 0x100+i: active word i, RO; write -> err.
- 0x200 CTRL, WO: bit0=1 starts a commit; bit1=1 sets the sticky global lock.
- 0x201 LOCK: write-1-to-set sticky per-master lock bits [NB_MASTER-1:0]; writing 0 has no effect; reads return the lock bits.
- 0x202 STATUS, RO: bit0 busy (FSM != IDLE), bit1 timeout (sticky), bit2 global lock, [31:16] violation count.
- Any other index: read returns 0 with err=1; write is ignored with err=1.

Bus timing:
- rvalid_o, rdata_o and err_o are registered, with 1-cycle latency.
- Back-to-back requests are allowed every cycle.

Locking:
- Master m is locked when reglk_ctrl_i[m] | lock_q[m] | glock_q.
- A write to a locked master's shadow word gives err=1, the shadow is unchanged, and it counts as a violation.
- lock_q and glock_q clear only on reset.

Read hiding:
- When rd_hide_i[m]=1, reads of master m's shadow and active words return 0 with err=0.

Unused bits:
- Bits of the last word per master beyond NB_PERIPHERALS*ACC_BITS are not stored; they read 0 and writes to them are dropped.

Commit FSM:
- IDLE: a CTRL bit0 write moves to WAIT_Q, clears cnt and clears the timeout bit.
- WAIT_Q: if commit_ok_i=1, go to COPY. Otherwise cnt++; when cnt==TIMEOUT-1, go to IDLE and set timeout. Active registers are unchanged.
- COPY: active <= all shadow, commit_done_o=1, then go to IDLE.
- While busy, shadow writes and CTRL bit0 writes get err=1 and are ignored.
- A CTRL write with bit0=1 and bit1=1 in IDLE does both: sets glock_q and starts the commit.

Reset values:
- Shadow, active, locks, cnt and status are 0; FSM is IDLE.
- All outputs are 0 (acc_ctrl_o=0, rvalid_o=0).
- A reset during WAIT_Q or COPY aborts with no partial update.

Optional Feature:
- ACCT_VIOL_CNT_EN defined: 16-bit saturating counter of rejected writes (locked-master writes, writes while busy, RO/unmapped writes), cleared only by reset, shown in STATUS[31:16].
- Not defined: no counter; STATUS[31:16] reads 0.

Test Plan:
1. Reset -> read 0x000, 0x400, 0x808 all return 0, err=0; acc_ctrl_o=0.
2. Write 0x000=0xDEADBEEF and 0x004=0xFFFFFFFF -> read 0x004 returns 0x0000000F and acc_ctrl_o stays 0. Then write 0x800=1 with commit_ok_i=1 -> commit_done_o pulses 2 cycles later and acc_ctrl_o[35:0]=36'hF_DEADBEEF.
3. commit_ok_i=0, write 0x800=1 -> STATUS=0x1 for 16 cycles, then STATUS=0x2; acc_ctrl_o unchanged. A shadow write during WAIT_Q -> err=1.
4. reglk_ctrl_i[1]=1, write 0x008 -> err=1, shadow unchanged, STATUS[31:16]=1 (macro on). Write 0x804=1 then 0x000 -> err=1. Write 0x804=0 -> lock_q still reads 0x1.
5. rd_hide_i[0]=1, read 0x000 after a committed 0xDEADBEEF -> rdata=0, err=0; acc_ctrl_o unaffected.
6. Write 0x400 -> err=1, active unchanged. Read 0x80C -> rdata=0, err=1. Assert rst_i during WAIT_Q -> FSM IDLE, all registers 0, no commit_done_o.

Source files
------------

// File: rtl/acct_regfile_multi.sv
// acct_regfile_multi: multi-master access-control register file.
// Software writes per-master permission words into shadow registers, then a commit
// FSM copies every shadow word to the live acc_ctrl_o vector at once when the
// fabric reports quiescence, or aborts after TIMEOUT cycles.
// Optional feature macro: ACCT_VIOL_CNT_EN enables a 16-bit saturating
// rejected-write counter reported in STATUS[31:16] (reads 0 when undefined).

module acct_regfile_multi #(
  parameter int NB_MASTER      = 2,
  parameter int NB_PERIPHERALS = 9,
  parameter int ACC_BITS       = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT        = 16
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       req_i,
  input  logic                                       we_i,
  input  logic [ADDR_WIDTH-1:0]                      addr_i,
  input  logic [31:0]                                wdata_i,
  output logic                                       gnt_o,
  output logic                                       rvalid_o,
  output logic [31:0]                                rdata_o,
  output logic                                       err_o,
  input  logic [NB_MASTER-1:0]                       reglk_ctrl_i,
  input  logic [NB_MASTER-1:0]                       rd_hide_i,
  input  logic                                       commit_ok_i,
  output logic [NB_MASTER*NB_PERIPHERALS*ACC_BITS-1:0] acc_ctrl_o,
  output logic                                       commit_done_o
);

  localparam int MB       = NB_PERIPHERALS * ACC_BITS;  // permission bits per master
  localparam int NW       = (MB + 31) / 32;             // words per master
  localparam int NSH      = NB_MASTER * NW;             // total shadow words
  localparam int ACT_BASE = 32'h100;
  localparam int CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_Q, ST_COPY} state_t;

  // Mask of the low n bits of a word; bits above MB in a master's last word are never stored.
  function automatic logic [31:0] low_mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << n) - 32'h1;
  endfunction

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_timeout;
  logic                r_glock;
  logic [NB_MASTER-1:0] r_lock;
  logic                r_commit_done;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic [31:0]          w_idx32;
  logic                 w_busy;
  logic [NB_MASTER-1:0] w_locked;
  logic [NSH-1:0]       w_hit_sh;
  logic [NSH-1:0]       w_hit_act;
  logic [NSH-1:0]       w_sh_rej;
  logic [NSH:0][31:0]   w_rd_chain;
  logic [15:0]          w_viol_cnt;
  logic [31:0]          w_status;
  logic [31:0]          w_rdata_next;
  logic                 w_err_next;
  logic                 w_reject;
  logic                 w_start;
  logic                 w_set_glock;
  logic                 w_lock_we;
  logic                 w_unused;

  assign w_idx32  = 32'(addr_i[ADDR_WIDTH-1:2]);
  assign w_busy   = (r_state != ST_IDLE);
  assign w_locked = reglk_ctrl_i | r_lock | {NB_MASTER{r_glock}};
  assign w_status = {w_viol_cnt, 13'd0, r_glock, r_timeout, w_busy};
  assign w_rd_chain[0] = 32'd0;

  // One slice per permission word: shadow/active storage, decode and read-mux stage.
  for (genvar gi = 0; gi < NSH; gi++) begin : g_word
    localparam int M  = gi / NW;
    localparam int W  = gi % NW;
    localparam int VB = (MB - W * 32 >= 32) ? 32 : (MB - W * 32);
    localparam logic [31:0] MASK = low_mask(VB);

    logic [31:0] r_sh;
    logic [31:0] r_act;
    logic        w_we;

    assign w_hit_sh[gi]  = req_i && (w_idx32 == 32'(gi));
    assign w_hit_act[gi] = req_i && (w_idx32 == 32'(ACT_BASE + gi));
    assign w_we          = w_hit_sh[gi] && we_i && !w_busy && !w_locked[M];
    assign w_sh_rej[gi]  = w_hit_sh[gi] && we_i && (w_busy || w_locked[M]);
    assign w_rd_chain[gi+1] = w_rd_chain[gi]
                            | ((w_hit_sh[gi]  && !rd_hide_i[M]) ? r_sh  : 32'd0)
                            | ((w_hit_act[gi] && !rd_hide_i[M]) ? r_act : 32'd0);

    // Shadow word: software-written, unused high bits dropped on write.
    always_ff @(posedge clk_i) begin
      if (rst_i)     r_sh <= 32'd0;
      else if (w_we) r_sh <= wdata_i & MASK;
    end

    // Active word: loaded from shadow only in the COPY state.
    always_ff @(posedge clk_i) begin
      if (rst_i)                   r_act <= 32'd0;
      else if (r_state == ST_COPY) r_act <= r_sh;
    end

    for (genvar gb = 0; gb < VB; gb++) begin : g_bit
      assign acc_ctrl_o[M * MB + W * 32 + gb] = r_act[gb];
    end
  end

  // Bus decode: read data, error and side-effect strobes for the current request.
  always_comb begin
    w_rdata_next = 32'd0;
    w_err_next   = 1'b0;
    w_start      = 1'b0;
    w_set_glock  = 1'b0;
    w_lock_we    = 1'b0;
    if (req_i) begin
      if (|w_hit_sh) begin
        if (we_i) w_err_next = |w_sh_rej;
        else      w_rdata_next = w_rd_chain[NSH];
      end else if (|w_hit_act) begin
        if (we_i) w_err_next = 1'b1;
        else      w_rdata_next = w_rd_chain[NSH];
      end else if (w_idx32 == 32'h200) begin
        if (we_i) begin
          if (wdata_i[0] && w_busy) begin
            w_err_next = 1'b1;
          end else begin
            w_start     = wdata_i[0];
            w_set_glock = wdata_i[1];
          end
        end
      end else if (w_idx32 == 32'h201) begin
        if (we_i) w_lock_we = 1'b1;
        else      w_rdata_next = 32'(r_lock);
      end else if (w_idx32 == 32'h202) begin
        if (we_i) w_err_next = 1'b1;
        else      w_rdata_next = w_status;
      end else begin
        w_err_next = 1'b1;
      end
    end
  end

  // Every write that answers with err is a rejected write.
  assign w_reject = req_i && we_i && w_err_next;

  // Commit FSM plus sticky lock/timeout flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_timeout     <= 1'b0;
      r_glock       <= 1'b0;
      r_lock        <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= 1'b0;
      if (w_set_glock) r_glock <= 1'b1;
      if (w_lock_we)   r_lock  <= r_lock | wdata_i[NB_MASTER-1:0];
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_WAIT_Q;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end
        end
        ST_WAIT_Q: begin
          if (commit_ok_i) begin
            r_state <= ST_COPY;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COPY: begin
          r_state       <= ST_IDLE;
          r_commit_done <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Registered bus response, one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rdata_next;
      r_err    <= w_err_next;
    end
  end

`ifdef ACCT_VIOL_CNT_EN
  logic [15:0] r_viol_cnt;

  // Saturating count of rejected writes, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  r_viol_cnt <= 16'd0;
    else if (w_reject && r_viol_cnt != 16'hFFFF) r_viol_cnt <= r_viol_cnt + 16'd1;
  end

  assign w_viol_cnt = r_viol_cnt;
  assign w_unused   = ^addr_i[1:0];
`else
  assign w_viol_cnt = 16'd0;
  assign w_unused   = ^{addr_i[1:0], w_reject};
`endif

  assign gnt_o         = req_i;
  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign err_o         = r_err;
  assign commit_done_o = r_commit_done;

endmodule

// File: tb/tb_acct_regfile_multi.sv
// Self-checking bench for acct_regfile_multi (default parameters) with a
// bit-vector reference model of the shadow/active permissions.
module tb_acct_regfile_multi;

  logic        clk_i, rst_i, req_i, we_i, commit_ok_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, commit_done_o;
  logic [31:0] rdata_o;
  logic [1:0]  reglk_ctrl_i, rd_hide_i;
  logic [71:0] acc_ctrl_o;

  acct_regfile_multi dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .reglk_ctrl_i(reglk_ctrl_i), .rd_hide_i(rd_hide_i),
    .commit_ok_i(commit_ok_i), .acc_ctrl_o(acc_ctrl_o), .commit_done_o(commit_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: each master's permissions as one 36-bit vector.
  logic [35:0] m_sh [2];
  logic [35:0] m_act[2];
  logic [1:0]  m_lock;
  logic        m_glock, m_timeout, m_busy;
  int          m_viol;

  function automatic logic [15:0] exp_viol();
`ifdef ACCT_VIOL_CNT_EN
    return 16'(m_viol);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_status();
    return {exp_viol(), 13'd0, m_glock, m_timeout, m_busy};
  endfunction

  function automatic logic [71:0] exp_acc();
    return {m_act[1], m_act[0]};
  endfunction

  task automatic model_reset();
    m_sh[0] = '0; m_sh[1] = '0; m_act[0] = '0; m_act[1] = '0;
    m_lock = '0; m_glock = 0; m_timeout = 0; m_busy = 0; m_viol = 0;
  endtask

  // Predict response of one bus access given the currently driven side inputs.
  task automatic model_access(input logic we, input logic [11:0] a, input logic [31:0] wd,
                              output logic [31:0] erd, output logic eer, output logic start);
    int idx, m, w;
    logic [63:0] t;
    logic [1:0] lk;
    idx = int'(a[11:2]);
    erd = '0; eer = 0; start = 0;
    lk = reglk_ctrl_i | m_lock | {2{m_glock}};
    if (idx < 4) begin
      m = idx / 2; w = idx % 2; t = {28'd0, m_sh[m]};
      if (we) begin
        if (m_busy || lk[m]) eer = 1;
        else begin t[w*32 +: 32] = wd; m_sh[m] = t[35:0]; end
      end else if (!rd_hide_i[m]) erd = t[w*32 +: 32];
    end else if (idx >= 'h100 && idx < 'h104) begin
      m = (idx - 'h100) / 2; w = (idx - 'h100) % 2; t = {28'd0, m_act[m]};
      if (we) eer = 1;
      else if (!rd_hide_i[m]) erd = t[w*32 +: 32];
    end else if (idx == 'h200) begin
      if (we) begin
        if (wd[0] && m_busy) eer = 1;
        else begin
          if (wd[1]) m_glock = 1;
          if (wd[0]) begin start = 1; m_busy = 1; m_timeout = 0; end
        end
      end
    end else if (idx == 'h201) begin
      if (we) m_lock = m_lock | wd[1:0];
      else    erd = {30'd0, m_lock};
    end else if (idx == 'h202) begin
      if (we) eer = 1;
      else    erd = exp_status();
    end else begin
      eer = 1;
    end
    if (we && eer && m_viol < 65535) m_viol++;
  endtask

  // One bus transaction; response sampled 1 ns after the next rising edge.
  task automatic bus(input logic we, input logic [11:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output logic rv);
    req_i = 1; we_i = we; addr_i = a; wdata_i = wd;
    @(posedge clk_i); #1;
    rd = rdata_o; er = err_o; rv = rvalid_o;
    req_i = 0; we_i = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1; req_i = 0; we_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; logic er, eer, rv, st;
    logic [11:0] addrs [3];
    apply_reset();
    total++; if (acc_ctrl_o !== 72'd0) begin bad++; $display("FAIL reset_acc: got %h want 0", acc_ctrl_o); end
    total++; if (rvalid_o !== 1'b0 || commit_done_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'd0) begin
      bad++; $display("FAIL reset_outs: rvalid=%b done=%b err=%b rdata=%h want all 0", rvalid_o, commit_done_o, err_o, rdata_o); end
    req_i = 1; #1;
    total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL gnt_hi: got %b want 1", gnt_o); end
    req_i = 0; #1;
    total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL gnt_lo: got %b want 0", gnt_o); end
    addrs[0] = 12'h000; addrs[1] = 12'h400; addrs[2] = 12'h808;
    for (int i = 0; i < 3; i++) begin
      model_access(0, addrs[i], 0, erd, eer, st);
      bus(0, addrs[i], 0, rd, er, rv);
      total++; if (rd !== erd || er !== eer || rv !== 1'b1) begin bad++;
        $display("FAIL reset_read_%03h: got rd=%h err=%b rv=%b want rd=%h err=%b rv=1", addrs[i], rd, er, rv, erd, eer); end
    end
  endtask

  task automatic test_commit();
    logic [31:0] rd, erd; logic er, eer, rv, st;
    commit_ok_i = 0;
    model_access(1, 12'h000, 32'hDEADBEEF, erd, eer, st); bus(1, 12'h000, 32'hDEADBEEF, rd, er, rv);
    total++; if (er !== eer) begin bad++; $display("FAIL wr_000: err got %b want %b", er, eer); end
    model_access(1, 12'h004, 32'hFFFFFFFF, erd, eer, st); bus(1, 12'h004, 32'hFFFFFFFF, rd, er, rv);
    total++; if (er !== eer) begin bad++; $display("FAIL wr_004: err got %b want %b", er, eer); end
    model_access(0, 12'h004, 0, erd, eer, st); bus(0, 12'h004, 0, rd, er, rv);
    total++; if (rd !== erd || rd !== 32'h0000000F) begin bad++; $display("FAIL rd_004_unused: got %h want %h", rd, erd); end
    total++; if (acc_ctrl_o !== 72'd0) begin bad++; $display("FAIL acc_before_commit: got %h want 0", acc_ctrl_o); end
    commit_ok_i = 1;
    model_access(1, 12'h800, 32'h1, erd, eer, st); bus(1, 12'h800, 32'h1, rd, er, rv);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ctrl_start: err got %b want 0", er); end
    @(posedge clk_i); #1;
    total++; if (commit_done_o !== 1'b0 || acc_ctrl_o !== 72'd0) begin bad++;
      $display("FAIL commit_early: done=%b acc=%h want done=0 acc=0", commit_done_o, acc_ctrl_o); end
    @(posedge clk_i); #1;
    m_act[0] = m_sh[0]; m_act[1] = m_sh[1]; m_busy = 0;
    total++; if (commit_done_o !== 1'b1) begin bad++; $display("FAIL commit_done: got %b want 1", commit_done_o); end
    total++; if (acc_ctrl_o[35:0] !== 36'hF_DEADBEEF || acc_ctrl_o !== exp_acc()) begin bad++;
      $display("FAIL commit_acc: got %h want %h", acc_ctrl_o, exp_acc()); end
    @(posedge clk_i); #1;
    total++; if (commit_done_o !== 1'b0) begin bad++; $display("FAIL commit_pulse: got %b want 0", commit_done_o); end
  endtask

  task automatic test_hide();
    logic [31:0] rd, erd; logic er, eer, rv, st;
    logic [11:0] addrs [4];
    addrs[0] = 12'h000; addrs[1] = 12'h400; addrs[2] = 12'h004; addrs[3] = 12'h008;
    rd_hide_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      model_access(0, addrs[i], 0, erd, eer, st);
      bus(0, addrs[i], 0, rd, er, rv);
      total++; if (rd !== erd || er !== eer) begin bad++;
        $display("FAIL hide_rd_%03h: got rd=%h err=%b want rd=%h err=%b", addrs[i], rd, er, erd, eer); end
    end
    total++; if (acc_ctrl_o !== exp_acc()) begin bad++; $display("FAIL hide_acc: got %h want %h", acc_ctrl_o, exp_acc()); end
    rd_hide_i = 2'b00;
  endtask

  task automatic test_timeout();
    logic [31:0] rd, erd, wd; logic er, eer, rv, st;
    commit_ok_i = 0;
    model_access(1, 12'h800, 32'h1, erd, eer, st); bus(1, 12'h800, 32'h1, rd, er, rv);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL to_start: err got %b want 0", er); end
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        wd = $urandom;
        model_access(1, 12'h008, wd, erd, eer, st); bus(1, 12'h008, wd, rd, er, rv);
        total++; if (er !== eer || er !== 1'b1) begin bad++; $display("FAIL busy_wr: err got %b want %b", er, eer); end
      end else begin
        model_access(0, 12'h808, 0, erd, eer, st); bus(0, 12'h808, 0, rd, er, rv);
        total++; if (rd !== erd) begin bad++; $display("FAIL busy_status_%0d: got %h want %h", i, rd, erd); end
      end
    end
    m_busy = 0; m_timeout = 1;
    model_access(0, 12'h808, 0, erd, eer, st); bus(0, 12'h808, 0, rd, er, rv);
    total++; if (rd !== erd) begin bad++; $display("FAIL timeout_status: got %h want %h", rd, erd); end
    total++; if (acc_ctrl_o !== exp_acc()) begin bad++; $display("FAIL timeout_acc: got %h want %h", acc_ctrl_o, exp_acc()); end
  endtask

  function automatic int pick_unmapped();
    case ($urandom_range(0, 2))
      0:       return 4 + $urandom_range(0, 251);
      1:       return 'h104 + $urandom_range(0, 251);
      default: return 'h203 + $urandom_range(0, 'h1FC);
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] rd, erd, wd; logic er, eer, rv, st, we;
    int op, idx, sel;
    logic [11:0] a;
    commit_ok_i = 1;
    for (int n = 0; n < 300; n++) begin
      reglk_ctrl_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rd_hide_i    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      op = $urandom_range(0, 9);
      wd = $urandom;
      we = 0;
      case (op)
        0, 1, 2, 3: begin idx = $urandom_range(0, 3); we = 1; end
        4, 5, 6: begin
          sel = $urandom_range(0, 9);
          if (sel < 4)       idx = sel;
          else if (sel < 8)  idx = 'h100 + sel - 4;
          else if (sel == 8) idx = 'h201;
          else               idx = 'h202;
        end
        7: begin
          we = 1;
          sel = $urandom_range(0, 2);
          idx = (sel == 0) ? 'h100 + $urandom_range(0, 3) : (sel == 1) ? 'h202 : pick_unmapped();
        end
        8: idx = pick_unmapped();
        default: begin idx = 'h200; we = 1; wd = ($urandom & 32'hFFFF_FFFC) | 32'h1; end
      endcase
      a = {10'(idx), 2'($urandom)};
      model_access(we, a, wd, erd, eer, st);
      bus(we, a, wd, rd, er, rv);
      total++; if (rv !== 1'b1 || rd !== erd || er !== eer) begin bad++;
        $display("FAIL rand_%0d we=%b a=%03h: got rv=%b rd=%h err=%b want rv=1 rd=%h err=%b", n, we, a, rv, rd, er, erd, eer); end
      total++; if (acc_ctrl_o !== exp_acc() || commit_done_o !== 1'b0) begin bad++;
        $display("FAIL rand_acc_%0d: got acc=%h done=%b want acc=%h done=0", n, acc_ctrl_o, commit_done_o, exp_acc()); end
      if (st) begin
        @(posedge clk_i); #1;
        total++; if (commit_done_o !== 1'b0 || rvalid_o !== 1'b0) begin bad++;
          $display("FAIL rand_wait_%0d: done=%b rvalid=%b want 0 0", n, commit_done_o, rvalid_o); end
        @(posedge clk_i); #1;
        m_act[0] = m_sh[0]; m_act[1] = m_sh[1]; m_busy = 0;
        total++; if (commit_done_o !== 1'b1 || acc_ctrl_o !== exp_acc()) begin bad++;
          $display("FAIL rand_commit_%0d: done=%b acc=%h want done=1 acc=%h", n, commit_done_o, acc_ctrl_o, exp_acc()); end
      end
    end
    reglk_ctrl_i = 0; rd_hide_i = 0;
  endtask

  typedef struct packed {
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
    logic [1:0]  lk;
  } step_t;

  task automatic test_lock();
    logic [31:0] rd, erd; logic er, eer, rv, st;
    step_t steps [11];
    steps[0]  = '{1'b1, 12'h008, 32'hA5A5A5A5, 2'b10};  // hardware-locked master 1
    steps[1]  = '{1'b0, 12'h008, 32'h0,        2'b10};
    steps[2]  = '{1'b0, 12'h808, 32'h0,        2'b00};
    steps[3]  = '{1'b1, 12'h804, 32'h1,        2'b00};  // sticky lock master 0
    steps[4]  = '{1'b1, 12'h000, 32'h12345678, 2'b00};
    steps[5]  = '{1'b1, 12'h804, 32'h0,        2'b00};
    steps[6]  = '{1'b0, 12'h804, 32'h0,        2'b00};
    steps[7]  = '{1'b1, 12'h00C, 32'h0000000B, 2'b00};  // master 1 still writable
    steps[8]  = '{1'b1, 12'h800, 32'h2,        2'b00};  // global lock only
    steps[9]  = '{1'b1, 12'h00C, 32'h00000003, 2'b00};
    steps[10] = '{1'b0, 12'h808, 32'h0,        2'b00};
    rd_hide_i = 0;
    for (int i = 0; i < 11; i++) begin
      reglk_ctrl_i = steps[i].lk;
      model_access(steps[i].we, steps[i].a, steps[i].d, erd, eer, st);
      bus(steps[i].we, steps[i].a, steps[i].d, rd, er, rv);
      total++; if (rd !== erd || er !== eer) begin bad++;
        $display("FAIL lock_step_%0d a=%03h: got rd=%h err=%b want rd=%h err=%b", i, steps[i].a, rd, er, erd, eer); end
    end
    reglk_ctrl_i = 0;
  endtask

  task automatic test_ro_reset();
    logic [31:0] rd, erd; logic er, eer, rv, st;
    step_t steps [3];
    steps[0] = '{1'b1, 12'h400, 32'hFFFF0000, 2'b00};
    steps[1] = '{1'b0, 12'h400, 32'h0,        2'b00};
    steps[2] = '{1'b0, 12'h80C, 32'h0,        2'b00};
    for (int i = 0; i < 3; i++) begin
      model_access(steps[i].we, steps[i].a, steps[i].d, erd, eer, st);
      bus(steps[i].we, steps[i].a, steps[i].d, rd, er, rv);
      total++; if (rd !== erd || er !== eer) begin bad++;
        $display("FAIL ro_step_%0d a=%03h: got rd=%h err=%b want rd=%h err=%b", i, steps[i].a, rd, er, erd, eer); end
    end
    total++; if (acc_ctrl_o !== exp_acc()) begin bad++; $display("FAIL ro_acc: got %h want %h", acc_ctrl_o, exp_acc()); end
    commit_ok_i = 0;
    model_access(1, 12'h800, 32'h1, erd, eer, st); bus(1, 12'h800, 32'h1, rd, er, rv);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rst_start: err got %b want 0", er); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      total++; if (commit_done_o !== 1'b0) begin bad++; $display("FAIL rst_wait_done_%0d: got %b want 0", i, commit_done_o); end
    end
    apply_reset();
    commit_ok_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      total++; if (commit_done_o !== 1'b0 || acc_ctrl_o !== 72'd0) begin bad++;
        $display("FAIL post_rst_%0d: done=%b acc=%h want 0 0", i, commit_done_o, acc_ctrl_o); end
    end
    steps[0] = '{1'b0, 12'h808, 32'h0, 2'b00};
    steps[1] = '{1'b0, 12'h000, 32'h0, 2'b00};
    steps[2] = '{1'b0, 12'h804, 32'h0, 2'b00};
    for (int i = 0; i < 3; i++) begin
      model_access(steps[i].we, steps[i].a, steps[i].d, erd, eer, st);
      bus(steps[i].we, steps[i].a, steps[i].d, rd, er, rv);
      total++; if (rd !== erd || rd !== 32'd0 || er !== 1'b0) begin bad++;
        $display("FAIL post_rst_rd_%03h: got rd=%h err=%b want rd=0 err=0", steps[i].a, rd, er); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
    reglk_ctrl_i = 0; rd_hide_i = 0; commit_ok_i = 0;
    model_reset();
    test_reset();
    test_commit();
    test_hide();
    test_timeout();
    test_random();
    test_lock();
    test_ro_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
